// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: emits a commanded number of chA/chB edges at a fixed
// clock spacing in either direction, with an index pulse and a running signed position.
module quad_encoder_gen #(
  parameter int EDGES_PER_REV = 48,
  parameter int MIN_PERIOD    = 4,
  parameter int PERIOD_W      = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_dir,
  input  logic [31:0]                      cmd_edges,
  input  logic [PERIOD_W-1:0]              cmd_period,
  input  logic                             abort,
  output logic                             chA,
  output logic                             chB,
  output logic                             idx,
  output logic                             busy,
  output logic                             done,
  output logic [31:0]                      position,
  output logic [1:0]                       dbg_state_o,
  output logic [$clog2(EDGES_PER_REV)-1:0] dbg_rev_pos_o
);

  // Command handshake: a move is accepted on any clock where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_valid at any other time is dropped, not queued.

  localparam int RW = $clog2(EDGES_PER_REV);
  localparam logic [RW-1:0]       REV_LAST = RW'(EDGES_PER_REV - 1);
  localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [31:0]         remaining_q, remaining_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic [RW-1:0]       rev_q, rev_d;
  logic                idx_q, idx_d;
  logic [31:0]         pos_q, pos_d;
  logic                edge_fire;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    timer_d     = timer_q;
    a_d         = a_q;
    b_d         = b_q;
    rev_d       = rev_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    edge_fire   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d       = cmd_dir;
          remaining_d = cmd_edges;
          period_d    = (cmd_period < MIN_P) ? MIN_P : cmd_period;
          timer_d     = '0;
          state_d     = (cmd_edges == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort takes priority over an edge that would fire on the same clock.
        if (abort) begin
          state_d = S_DONE;
        end else if (timer_q == period_q - PERIOD_W'(1)) begin
          edge_fire   = 1'b1;
          timer_d     = '0;
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) state_d = S_DONE;
        end else begin
          timer_d = timer_q + PERIOD_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Gray stepping: forward toggles A when A==B, else B; reverse is the mirror.
    if (edge_fire) begin
      if (dir_q ^ (a_q != b_q)) a_d = ~a_q;
      else                      b_d = ~b_q;
      if (dir_q) begin
        rev_d = (rev_q == REV_LAST) ? '0 : rev_q + RW'(1);
        pos_d = pos_q + 32'd1;
      end else begin
        rev_d = (rev_q == '0) ? REV_LAST : rev_q - RW'(1);
        pos_d = pos_q - 32'd1;
      end
      idx_d = (rev_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      period_q    <= MIN_P;
      timer_q     <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      rev_q       <= '0;
      idx_q       <= 1'b1;
      pos_q       <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rev_q       <= rev_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign chA           = a_q;
  assign chB           = b_q;
  assign idx           = idx_q;
  assign position      = pos_q;
  assign dbg_state_o   = state_q;
  assign dbg_rev_pos_o = rev_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: random and directed moves, expected edges queued per move
// and popped by a monitor on every chA/chB change; a small decoder model runs in loopback.
module tb_quad_encoder_gen;

  localparam int EPR  = 48;
  localparam int MINP = 4;
  localparam int PW   = 32;
  localparam int RW   = 6;
  localparam int EW   = 32 + 2 + 1 + RW + 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [31:0]   cmd_edges;
  logic [PW-1:0] cmd_period;
  logic          abort;
  logic          chA, chB, idx, busy, done;
  logic [31:0]   position;
  logic [1:0]    dbg_state;
  logic [RW-1:0] dbg_rev_pos;

  quad_encoder_gen #(.EDGES_PER_REV(EPR), .MIN_PERIOD(MINP), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_edges(cmd_edges), .cmd_period(cmd_period), .abort(abort),
    .chA(chA), .chB(chB), .idx(idx), .busy(busy), .done(done), .position(position),
    .dbg_state_o(dbg_state), .dbg_rev_pos_o(dbg_rev_pos)
  );

  // Clock / reset bookkeeping
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_applied = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_applied <= rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state and reference model
  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp_done_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  int            m_phase = 0;
  int            m_rev   = 0;
  logic [31:0]   m_pos   = 32'd0;

  function automatic logic [1:0] ab_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_edge(input bit dir, input int unsigned at_cyc);
    if (dir) begin
      m_phase = (m_phase + 1) % 4;
      m_rev   = (m_rev + 1) % EPR;
      m_pos   = m_pos + 32'd1;
    end else begin
      m_phase = (m_phase + 3) % 4;
      m_rev   = (m_rev + EPR - 1) % EPR;
      m_pos   = m_pos - 32'd1;
    end
    exp_q.push_back({at_cyc, ab_of(m_phase), (m_rev == 0), RW'(m_rev), m_pos});
  endtask

  // Monitor: every chA/chB change and every done pulse must match the head of its queue
  logic [1:0]    prev_ab = 2'b00;
  logic [EW-1:0] mon_e;
  logic [31:0]   mon_d;
  always @(negedge clk) begin
    if (rst_applied) begin
      check("reset_state", {chA, chB, idx, busy, done, cmd_ready, position, dbg_rev_pos},
            {2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 6'd0});
    end else begin
      if ({chA, chB} !== prev_ab) begin
        if (exp_q.size() == 0) begin
          check("unexpected_edge", {chA, chB}, prev_ab);
        end else begin
          mon_e = exp_q.pop_front();
          check("edge", {cyc, chA, chB, idx, dbg_rev_pos, position}, mon_e);
        end
      end
      if (done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          mon_d = exp_done_q.pop_front();
          check("done_cycle", cyc, mon_d);
        end
      end
    end
    prev_ab = {chA, chB};
  end

  // Loopback decoder: 2-flop sync plus edge detect, counts signed phase steps
  logic [1:0] d_s1, d_s2, d_s3;
  int         dec_count;
  always @(posedge clk) begin
    if (rst) begin
      d_s1      <= 2'b00;
      d_s2      <= 2'b00;
      d_s3      <= 2'b00;
      dec_count <= 0;
    end else begin
      d_s1 <= {chA, chB};
      d_s2 <= d_s1;
      d_s3 <= d_s2;
      if (d_s3 != d_s2)
        dec_count <= dec_count + ((((ph_of(d_s2) - ph_of(d_s3)) & 3) == 1) ? 1 : -1);
    end
  end

  // Driver tasks
  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", done, 1'b1);
    end else begin
      check("ready_during_done", cmd_ready, 1'b0);
      @(negedge clk);
      check("ready_after_done", cmd_ready, 1'b1);
    end
  endtask

  task automatic check_decoder();
    repeat (4) @(negedge clk);
    check("decoder_count", $unsigned(dec_count), m_pos);
  endtask

  task automatic run_move(input bit dir, input int unsigned edges, input int unsigned period,
                          input int unsigned abort_at, input bit hold_valid,
                          input int unsigned rst_after);
    int unsigned p, n, t0;
    p = (period < MINP) ? MINP : period;
    cmd_dir    = dir;
    cmd_edges  = edges;
    cmd_period = PW'(period);
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (hold_valid) begin
      cmd_dir    = ~dir;
      cmd_edges  = 32'd3;
      cmd_period = PW'(5);
    end else begin
      cmd_valid = 1'b0;
    end
    n = edges;
    if (abort_at != 0 && abort_at <= edges) n = abort_at - 1;
    if (rst_after != 0) n = rst_after;
    for (int k = 1; k <= int'(n); k++) push_edge(dir, t0 + k * p);
    if (rst_after == 0)
      exp_done_q.push_back((abort_at != 0 && abort_at <= edges) ? t0 + abort_at * p : t0 + edges * p);
    if (hold_valid) begin
      wait_until(t0 + 2);
      cmd_valid = 1'b0;
    end
    if (abort_at != 0 && abort_at <= edges) begin
      wait_until(t0 + abort_at * p - 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    if (rst_after != 0) begin
      wait_until(t0 + rst_after * p + 1);
      rst = 1'b1;
      exp_q.delete();
      exp_done_q.delete();
      m_phase = 0;
      m_rev   = 0;
      m_pos   = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3 * p) @(posedge clk);
      @(negedge clk);
    end else begin
      wait_done(int'(edges * p) + 10);
    end
  endtask

  // Stimulus
  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_edges  = 32'd0;
    cmd_period = '0;
    abort      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    run_move(1'b0, 4, 6, 0, 1'b0, 0);     // reverse from 00: rev_pos 44, position -4
    check_decoder();
    run_move(1'b1, 8, 4, 0, 1'b0, 0);     // forward 8 at the minimum period
    run_move(1'b1, 3, 1, 0, 1'b0, 0);     // period clamped up
    run_move(1'b0, 3, 0, 0, 1'b0, 0);
    run_move(1'b1, 0, 9, 0, 1'b0, 0);     // zero edges: done next cycle, nothing moves
    run_move(1'b1, 10, 4, 3, 1'b1, 0);    // abort on edge 3, extra cmd_valid ignored
    run_move(1'b1, 12, 4, 0, 1'b0, 5);    // reset mid-move after 5 edges
    run_move(1'b1, 48, 4, 0, 1'b0, 0);    // full revolution: idx back high on edge 48
    check_decoder();

    for (int i = 0; i < 20; i++) begin
      bit          r_dir, r_hold;
      int unsigned r_edges, r_period, r_abort;
      r_dir    = 1'($urandom_range(0, 1));
      r_edges  = $urandom_range(0, 10);
      r_period = $urandom_range(0, 7);
      r_abort  = 0;
      r_hold   = 1'b0;
      if (r_edges > 0 && $urandom_range(0, 3) == 0) r_abort = $urandom_range(1, r_edges);
      if (r_edges > 0 && $urandom_range(0, 2) == 0) r_hold = 1'b1;
      run_move(r_dir, r_edges, r_period, r_abort, r_hold, 0);
    end
    check_decoder();

    check("edge_queue_drained", exp_q.size(), 0);
    check("done_queue_drained", exp_done_q.size(), 0);
    check("final_position", position, m_pos);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
